id_issue_stage: RTL
===================

# id_issue_stage

Parametrised decode/issue stage for the in-order RV32 pipeline. It holds the general-purpose register file with same-cycle writeback bypass and a pending-write scoreboard, and it drives the ID/EX pipeline register through a valid/ready handshake with flush and stall. It sits between the IF/ID register (upstream) and the execute stage (downstream), and accepts the writeback port from the WB stage.

## Interface
- XLEN, 32: data and PC width.
- NREGS, 32: architectural register count; legal values are 16 (RV32E) or 32.
- SB_EN, 1: 1 enables scoreboard hazard stalls; 0 disables them, so id_ready_o never depends on register state.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_valid_i  in  1  IF/ID holds a valid instruction
- id_ready_o  out  1  stage accepts the ID instruction this cycle
- id_pc_i  in  XLEN  PC of the ID instruction
- id_inst_i  in  32  raw instruction; rs1=[19:15], rs2=[24:20], rd=[11:7]
- id_writes_rd_i  in  1  decoded flag: the instruction writes rd
- flush_i  in  1  kill ID/EX contents (branch/jump taken in EX)
- ex_valid_o  out  1  ID/EX register holds a valid instruction
- ex_ready_i  in  1  EX consumes ID/EX this cycle
- ex_pc_o  out  XLEN  registered PC
- ex_inst_o  out  32  registered instruction
- ex_rs1_o, ex_rs2_o  out  XLEN  registered operand values
- wb_en_i  in  1  writeback strobe
- wb_rd_i  in  5  writeback destination
- wb_data_i  in  XLEN  writeback data

## Operation
- **Register file**
  - Writes occur on posedge clk when wb_en_i=1, wb_rd_i≠0 and wb_rd_i<NREGS. Other writes are ignored.
  - x0 always reads 0.
  - An address ≥NREGS reads 0.
- **Read bypass**
  - If wb_en_i=1, wb_rd_i equals the read address, and that address is nonzero and <NREGS, the read returns wb_data_i in the same cycle.
  - No negedge writes.
- **Scoreboard** (only when SB_EN=1)
  - One pending bit per register. x0 is never pending.
  - A bit is set on issue when id_writes_rd_i=1 and rd≠0.
  - A bit is cleared on a valid writeback to that register.
  - eff_pending = pending & ~writeback-clear of the same cycle.
  - hazard = eff_pending[rs1] | eff_pending[rs2] | (id_writes_rd_i & eff_pending[rd]). The rd term is a WAW guard that keeps one outstanding writer per register.
  - If set and clear hit the same register in the same cycle, set wins.
- **Handshake**
  - issue = id_valid_i & id_ready_o.
  - id_ready_o = ~flush_i & ~hazard & (~ex_valid_o | ex_ready_i). This path is combinational.
- **ID/EX register update, in priority order:**
  1. reset: all registers 0, ex_valid_o=0, all ex_* outputs 0, scoreboard cleared.
  2. flush_i: ex_valid_o←0 and ex_* payload←0. If ex_valid_o=1 and the EX instruction wrote rd, its pending bit is cleared. The ID instruction is not consumed.
  3. ex_valid_o=1 and ex_ready_i=0 (stall): hold all ex_* outputs.
  4. issue: load pc, inst, bypassed rs1/rs2; ex_valid_o←1. A registered ex_writes_rd copy is kept internally for flush cleanup.
  5. Otherwise (bubble): ex_valid_o←0 and payload←0.
- Reset in the middle of an operation discards every in-flight state.

## Timing
- Issue to ex_valid_o: 1 cycle.
- Writeback to dependent read: 0 cycles via the bypass. A dependent instruction in ID issues in the same cycle the writeback arrives.
- Stalling is loss-free: an instruction is neither duplicated nor dropped across any number of stall cycles.
- Flush takes effect on the next edge. ex_valid_o is 0 in the cycle after flush_i=1, regardless of ex_ready_i.
- Full throughput is one issue per cycle with no hazards and ex_ready_i held at 1.

## Structure
- Package decode_pkg:
  - XLEN default
  - reg_addr_t (5-bit)
  - field-position constants RS1_LSB=15, RS2_LSB=20, RD_LSB=7
  - NOP/bubble encoding constant (all zero)
- Sub-module gpr_file: register array, x0/NREGS masking, two read ports with bypass, one write port.
- Scoreboard and ID/EX register stay in the top module.

## Test plan
- **Reset:** reset 1 cycle with all inputs 0 → ex_valid_o=0; ex_pc_o, ex_inst_o, ex_rs1_o and ex_rs2_o all 0; id_ready_o=1. A read of x5 returns 0.
- **Write-bypass:**
  - Stimulus: wb x3←0xDEADBEEF in the same cycle that ID presents add rs1=x3, rs2=x0, with ex_ready_i=1.
  - Response: the next cycle shows ex_rs1_o=0xDEADBEEF, ex_rs2_o=0, ex_valid_o=1.
- **Scoreboard stall:**
  - Stimulus: issue a write to x7. Then present an instruction reading x7 and hold it for 3 cycles with no wb. Then apply wb x7←0x11.
  - Response: id_ready_o=0 for 3 cycles; on the wb cycle id_ready_o=1 and the dependent instruction enters EX with ex_rs1_o=0x11.
- **Downstream stall:**
  - Stimulus: ex_valid_o=1 with pc=0x100, then ex_ready_i=0 for 4 cycles.
  - Response: ex_pc_o stays 0x100 and id_ready_o=0 throughout; the next ID instruction issues on the cycle ex_ready_i returns to 1.
- **Flush:**
  - Stimulus: EX holds a write to x9, then flush_i=1 with ex_ready_i=0.
  - Response: ex_valid_o=0 and ex_inst_o=0 on the next cycle; pending[x9] is cleared, so a following read of x9 issues without a stall.
- **RV32E (NREGS=16):**
  - Stimulus: wb to x20←5, then read x20.
  - Response: the read returns 0 and no scoreboard bit is set for rd=x20.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions for the ID stage: instruction field positions,
// register address type and small register-mask helpers.
package decode_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef logic [4:0] reg_addr_t;

  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;
  localparam int unsigned RD_LSB  = 7;

  // Bubble / NOP encoding loaded into ID/EX when nothing is issued
  localparam logic [31:0] NOP_INST = '0;

  function automatic reg_addr_t get_rs1(input logic [31:0] inst);
    return inst[RS1_LSB +: 5];
  endfunction

  function automatic reg_addr_t get_rs2(input logic [31:0] inst);
    return inst[RS2_LSB +: 5];
  endfunction

  function automatic reg_addr_t get_rd(input logic [31:0] inst);
    return inst[RD_LSB +: 5];
  endfunction

  // Nonzero and inside the implemented register range
  function automatic logic addr_writable(input reg_addr_t a, input int unsigned nregs);
    return (a != '0) && ({27'd0, a} < nregs);
  endfunction

  function automatic logic [31:0] reg_onehot(input reg_addr_t a);
    logic [31:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/gpr_file.sv
// General-purpose register file: one write port, two read ports with
// same-cycle writeback bypass, x0 and out-of-range addresses read as zero.
module gpr_file
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  reg_addr_t       waddr,
  input  logic [XLEN-1:0] wdata,
  input  reg_addr_t       raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  reg_addr_t       raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_ok;

  assign wr_ok = we && addr_writable(waddr, NREGS);

  // Storage update; writes to x0 or beyond NREGS are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (wr_ok) begin
      regs[waddr[AW-1:0]] <= wdata;
    end
  end

  // Read port A with writeback bypass
  always_comb begin
    rdata_a = '0;
    if (addr_writable(raddr_a, NREGS)) begin
      if (wr_ok && (waddr == raddr_a)) begin
        rdata_a = wdata;
      end else begin
        rdata_a = regs[raddr_a[AW-1:0]];
      end
    end
  end

  // Read port B with writeback bypass
  always_comb begin
    rdata_b = '0;
    if (addr_writable(raddr_b, NREGS)) begin
      if (wr_ok && (waddr == raddr_b)) begin
        rdata_b = wdata;
      end else begin
        rdata_b = regs[raddr_b[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: register read with bypass, pending-write scoreboard
// and the ID/EX pipeline register with valid/ready, stall and flush.
module id_issue_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned NREGS = 32,
  parameter bit          SB_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [31:0]     id_inst_i,
  input  logic            id_writes_rd_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [31:0]     ex_inst_o,
  output logic [XLEN-1:0] ex_rs1_o,
  output logic [XLEN-1:0] ex_rs2_o,
  input  logic            wb_en_i,
  input  reg_addr_t       wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i
);

  reg_addr_t       id_rs1, id_rs2, id_rd, ex_rd;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            wb_valid;
  logic            hazard;
  logic            issue;
  logic            ex_writes_rd;
  logic [31:0]     pending;
  logic [31:0]     eff_pending;
  logic [31:0]     wb_clr;
  logic [31:0]     flush_clr;
  logic [31:0]     issue_set;

  assign id_rs1   = get_rs1(id_inst_i);
  assign id_rs2   = get_rs2(id_inst_i);
  assign id_rd    = get_rd(id_inst_i);
  assign ex_rd    = get_rd(ex_inst_o);
  assign wb_valid = wb_en_i && addr_writable(wb_rd_i, NREGS);

  gpr_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_gpr_file (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_en_i),
    .waddr   (wb_rd_i),
    .wdata   (wb_data_i),
    .raddr_a (id_rs1),
    .rdata_a (rs1_val),
    .raddr_b (id_rs2),
    .rdata_b (rs2_val)
  );

  // Hazard check against pending writes, ignoring ones retired this cycle
  always_comb begin
    wb_clr      = wb_valid ? reg_onehot(wb_rd_i) : '0;
    eff_pending = pending & ~wb_clr;
    hazard      = 1'b0;
    if (SB_EN) begin
      hazard = eff_pending[id_rs1] | eff_pending[id_rs2]
             | (id_writes_rd_i & eff_pending[id_rd]);
    end
  end

  assign id_ready_o = ~flush_i & ~hazard & (~ex_valid_o | ex_ready_i);
  assign issue      = id_valid_i & id_ready_o;

  // Scoreboard set/clear masks for this cycle
  always_comb begin
    issue_set = '0;
    flush_clr = '0;
    if (issue && id_writes_rd_i && addr_writable(id_rd, NREGS)) begin
      issue_set = reg_onehot(id_rd);
    end
    if (flush_i && ex_valid_o && ex_writes_rd) begin
      flush_clr = reg_onehot(ex_rd);
    end
  end

  // Pending-write bits; a set in the same cycle as a clear takes priority
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else if (SB_EN) begin
      pending <= (pending & ~wb_clr & ~flush_clr) | issue_set;
    end
  end

  // ID/EX register: flush, then downstream stall, then issue, else bubble
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      ex_valid_o   <= 1'b0;
      ex_pc_o      <= '0;
      ex_inst_o    <= NOP_INST;
      ex_rs1_o     <= '0;
      ex_rs2_o     <= '0;
      ex_writes_rd <= 1'b0;
    end else if (ex_valid_o && !ex_ready_i) begin
      ex_valid_o   <= ex_valid_o;
    end else if (issue) begin
      ex_valid_o   <= 1'b1;
      ex_pc_o      <= id_pc_i;
      ex_inst_o    <= id_inst_i;
      ex_rs1_o     <= rs1_val;
      ex_rs2_o     <= rs2_val;
      ex_writes_rd <= id_writes_rd_i;
    end else begin
      ex_valid_o   <= 1'b0;
      ex_pc_o      <= '0;
      ex_inst_o    <= NOP_INST;
      ex_rs1_o     <= '0;
      ex_rs2_o     <= '0;
      ex_writes_rd <= 1'b0;
    end
  end

endmodule
